mesi_cache_top: RTL and testbench
=================================

# mesi_cache_top

- Four-core snooping cache subsystem.
- Each core has a private direct-mapped L1 with MESI coherence.
- All L1s share one snoop bus and one read-only memory refill port.
- Sits between four core request ports and an external memory model. Resolves hits locally, misses and upgrades over the bus.

## Interface
- NUM_LINES, 4: lines per L1 (power of two). Block is 128 bits (4 words). Address split: word [3:2], index [3+log2(NUM_LINES):4], tag above.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- read  in  4  per-core read request.
- write  in  4  per-core write request (wins if read also set).
- pr_addr  in  4x32  per-core byte address.
- pr_data  in  4x32  per-core write data.
- Core_send  in  4  per-core request valid.
- c_flush  in  4  per-core invalidate-all strobe.
- mem_read_data  in  128  refill block from memory.
- mem_ready  in  1  refill block valid.
- data_out_pr  out  4x32  per-core read data, registered, held until next completion.
- stall, stall_1, stall_2, stall_3  out  1 each  stall for core 0, 1, 2, 3.

## Operation
- Request i: Core_send[i] & (read[i] | write[i]). Core holds request stable while its stall is high.
- Local hit:
  - Read hit in S, E or M.
  - Write hit in E or M. Write sets line to M.
  - Completes at next edge, no stall.
- Otherwise (miss, or write hit in S) the request needs the bus. stall_i = request & ~local_hit, combinational.
- Bus FSM states: IDLE, SNOOP, MEM, FILL.
  - IDLE: arbiter picks one stalled core. Next state SNOOP.
  - SNOOP: other caches look up the address.
    - BusRd (read miss): any M/E/S copy supplies the block (cache-to-cache), then goes to S. Requester fills S. No copy: requester fills E from memory.
    - BusRdX (write miss): holder supplies block, all others go to I. Requester fills M with pr_data merged into the word.
    - BusUpgr (write hit S): others S to I, requester goes to M. Next state FILL.
    - Block supplied by a cache: next state FILL. Otherwise: next state MEM.
  - MEM: wait for mem_ready, latch mem_read_data. Next state FILL.
  - FILL: write line and state, update data_out_pr (writes echo the written word). Next state IDLE. The request now hits, so stall drops.
- Memory address is not exported. External model returns the block for the current miss.
- Replacement overwrites the indexed line. Dirty (M) data is discarded; there is no write-back port.
- c_flush[i]: invalidates all lines of cache i at next edge.
- Same-edge priority on one line: fill > snoop > flush > local write.
- During SNOOP, a non-owner local access to the snooped index is forced to a miss (stalls).

## Timing
- Reset values:
  - All lines I, tags/data 0.
  - data_out_pr all 0.
  - FSM IDLE, arbiter pointer at core 0.
  - All stalls 0 while rst is high.
- Reset mid-transaction aborts: FSM to IDLE, no fill.
- Latency from request to stall low:
  - Hit: 0 cycles stall, data at next edge.
  - Cache-to-cache: 3 edges (IDLE, SNOOP, FILL).
  - Memory: 4 edges with mem_ready already high, plus 1 per cycle mem_ready is low.
- One bus transaction at a time. Other requests stay stalled.

## Configuration
- MESI_RR_ARB_EN defined: round-robin arbitration. The pointer moves past the granted core after each FILL.
- Undefined: fixed priority, core 0 highest, core 3 lowest.

## Structure
- Shared package mesi_pkg:
  - Line state enum {I, S, E, M}.
  - Bus FSM enum.
  - Bus op enum {BusRd, BusRdX, BusUpgr}.
  - NUM_CORES=4, block/word width constants.
- Sub-module mesi_l1_cache, instantiated four times. Holds tag/state/data arrays, local hit logic and snoop response.
- The top holds the arbiter and bus FSM.

## Test plan
- Reset: rst high 2 cycles, then low. All stalls 0, data_out_pr all 0.
- Four simultaneous reads, mem_ready=1, mem_read_data=128'h123456789ABCDEF0123456789ABCDEF0:
  - Cores 0/1 read 0x11111000, cores 2/3 read 0x10000000.
  - Service order 0,1,2,3. Each data_out_pr = 32'h9ABCDEF0.
  - Core 0 E to S after core 1 fills S from cache; core 2 E to S after core 3 fills S from cache.
  - Core 0 stall low after 4 edges.
- Read hit: core 0 reads 0x11111004 after the fill. data_out_pr[0]=32'h12345678 next edge, stall 0.
- Upgrade: cores 0/1 both S on 0x11111000; core 1 writes 32'hDEADBEEF. Core 1 M, core 0 I. A core 0 re-read gets 32'hDEADBEEF cache-to-cache; both end S.
- Flush: c_flush=4'b0001, then core 0 reads 0x11111000. Miss; stall high for the bus transaction.
- Memory wait: write miss with mem_ready low 5 cycles. stall held 5 extra cycles, then line M.

Source files
------------

// File: rtl/mesi_pkg.sv
// Shared types and helpers for the four-core MESI snooping cache subsystem.
//   - line_state_t : per-line coherence state
//   - bus_state_t  : shared snoop bus controller state
//   - bus_op_t     : transaction type placed on the snoop bus
//   - arb_pick     : first requester at or after a starting pointer
//   - get_word / merge_word : 32-bit word access inside a 128-bit block
package mesi_pkg;

  localparam int NUM_CORES = 4;
  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;

  typedef enum logic [1:0] {I, S, E, M} line_state_t;
  typedef enum logic [1:0] {IDLE, SNOOP, MEM, FILL} bus_state_t;
  typedef enum logic [1:0] {BUS_RD, BUS_RDX, BUS_UPGR} bus_op_t;

  // Scans requesters starting at ptr, wrapping; ptr = 0 gives fixed priority.
  function automatic logic [1:0] arb_pick(input logic [NUM_CORES-1:0] req,
                                          input logic [1:0] ptr);
    logic [1:0] c;
    logic       found;
    arb_pick = ptr;
    found    = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      c = ptr + 2'(k);
      if (!found && req[c]) begin
        arb_pick = c;
        found    = 1'b1;
      end
    end
  endfunction

  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                 input logic [1:0] sel);
    return blk[{sel, 5'd0} +: WORD_W];
  endfunction

  function automatic logic [BLOCK_W-1:0] merge_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [1:0] sel,
                                                    input logic [WORD_W-1:0] w);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[{sel, 5'd0} +: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/mesi_cache_top_l1_cache.sv
// mesi_l1_cache: one private direct-mapped L1 with MESI state.
// Holds tag/state/data arrays, the local hit decision, snoop lookup and
// snoop state response, and the registered per-core read data.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, wr, addr, wdata core access (wr = write, else read)
//   flush               invalidate every line at the next edge
//   local_hit           access completes locally at the next edge
//   hit_s               tag match on a line in S (write here needs BusUpgr)
//   rd_data             registered read data / echoed write data
//   snoop_valid, snoop_op, bus_addr   snoop from the bus (non-requester only)
//   snoop_hit, snoop_data             valid copy of bus_addr and its block
//   fill_en, fill_state, fill_data    line write at bus_addr (requester only)
module mesi_l1_cache
  import mesi_pkg::*;
#(
  parameter int NUM_LINES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               wr,
  input  logic [31:0]        addr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic               flush,
  output logic               local_hit,
  output logic               hit_s,
  output logic [WORD_W-1:0]  rd_data,
  input  logic               snoop_valid,
  input  bus_op_t            snoop_op,
  input  logic [31:0]        bus_addr,
  output logic               snoop_hit,
  output logic [BLOCK_W-1:0] snoop_data,
  input  logic               fill_en,
  input  line_state_t        fill_state,
  input  logic [BLOCK_W-1:0] fill_data
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 4 - IDX_W;

  line_state_t        state_q [NUM_LINES];
  logic [TAG_W-1:0]   tag_q   [NUM_LINES];
  logic [BLOCK_W-1:0] data_q  [NUM_LINES];

  logic [IDX_W-1:0] idx, sidx;
  logic [TAG_W-1:0] tag, stag;
  logic [1:0]       word, fword;
  logic             tag_match, snoop_block;
  logic             unused_addr_bits;

  assign idx   = addr[4 +: IDX_W];
  assign tag   = addr[31 -: TAG_W];
  assign word  = addr[3:2];
  assign sidx  = bus_addr[4 +: IDX_W];
  assign stag  = bus_addr[31 -: TAG_W];
  assign fword = bus_addr[3:2];
  assign unused_addr_bits = ^{addr[1:0], bus_addr[1:0]};

  assign tag_match = (state_q[idx] != I) && (tag_q[idx] == tag);
  // While the bus snoops an index, local accesses to it must wait so the
  // snoop state change cannot race a local upgrade to M.
  assign snoop_block = snoop_valid && (sidx == idx);
  assign local_hit = tag_match && !snoop_block &&
                     (!wr || state_q[idx] == E || state_q[idx] == M);
  assign hit_s      = tag_match && (state_q[idx] == S);
  assign snoop_hit  = (state_q[sidx] != I) && (tag_q[sidx] == stag);
  assign snoop_data = data_q[sidx];

  // Updates are written lowest priority first so later assignments win:
  // local write < flush < snoop < fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_LINES; j++) begin
        state_q[j] <= I;
        tag_q[j]   <= '0;
        data_q[j]  <= '0;
      end
      rd_data <= '0;
    end else begin
      if (req && wr && local_hit) begin
        data_q[idx]  <= merge_word(data_q[idx], word, wdata);
        state_q[idx] <= M;
      end
      if (flush) begin
        for (int j = 0; j < NUM_LINES; j++) state_q[j] <= I;
      end
      if (snoop_valid && snoop_hit) begin
        state_q[sidx] <= (snoop_op == BUS_RD) ? S : I;
      end
      if (fill_en) begin
        tag_q[sidx]   <= stag;
        data_q[sidx]  <= fill_data;
        state_q[sidx] <= fill_state;
      end

      if (fill_en) begin
        rd_data <= get_word(fill_data, fword);
      end else if (req && local_hit) begin
        rd_data <= wr ? wdata : get_word(data_q[idx], word);
      end
    end
  end

endmodule

// File: rtl/mesi_cache_top.sv
// mesi_cache_top: four private MESI L1 caches sharing one snoop bus and a
// read-only memory refill port. Hits complete locally; misses and
// upgrades are serialised through the bus controller below.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   read, write, Core_send   per-core request (write wins over read)
//   pr_addr, pr_data         per-core byte address / write data
//   c_flush                  per-core invalidate-all strobe
//   mem_read_data, mem_ready refill block for the current miss
//   data_out_pr              per-core registered read/echo data
//   stall, stall_1..stall_3  per-core stall
// Build option: MESI_RR_ARB_EN selects round-robin arbitration; without it
// core 0 has the highest fixed priority.
//
// Bus FSM:
//   state | meaning
//   IDLE  | pick one stalled core, latch its request
//   SNOOP | other caches look up; supply block / downgrade / invalidate
//   MEM   | no cache supplied: wait for mem_ready, latch refill block
//   FILL  | write requester line and state, update its data_out_pr
module mesi_cache_top
  import mesi_pkg::*;
#(
  parameter int NUM_LINES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CORES-1:0]             read,
  input  logic [NUM_CORES-1:0]             write,
  input  logic [NUM_CORES-1:0][31:0]       pr_addr,
  input  logic [NUM_CORES-1:0][WORD_W-1:0] pr_data,
  input  logic [NUM_CORES-1:0]             Core_send,
  input  logic [NUM_CORES-1:0]             c_flush,
  input  logic [BLOCK_W-1:0]               mem_read_data,
  input  logic                             mem_ready,
  output logic [NUM_CORES-1:0][WORD_W-1:0] data_out_pr,
  output logic                             stall,
  output logic                             stall_1,
  output logic                             stall_2,
  output logic                             stall_3
);

  logic [NUM_CORES-1:0]              req, local_hit, hit_s, snoop_hit;
  logic [NUM_CORES-1:0]              snoop_valid, fill_en, stalled, stall_vec;
  logic [NUM_CORES-1:0][BLOCK_W-1:0] snoop_data;
  logic [NUM_CORES-1:0]              grant_oh;

  bus_state_t         state_q, state_d;
  logic [1:0]         grant_q, pick;
  bus_op_t            op_q, pick_op;
  logic [31:0]        addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [BLOCK_W-1:0] bus_data_q, fill_data, supply_data;
  line_state_t        fill_state_q;
  logic               supplied;

  assign req       = Core_send & (read | write);
  assign stalled   = req & ~local_hit;
  assign stall_vec = rst ? '0 : stalled;
  assign stall     = stall_vec[0];
  assign stall_1   = stall_vec[1];
  assign stall_2   = stall_vec[2];
  assign stall_3   = stall_vec[3];

  assign grant_oh    = 4'b0001 << grant_q;
  assign snoop_valid = (state_q == SNOOP) ? ~grant_oh : '0;
  assign fill_en     = (state_q == FILL) ? grant_oh : '0;

`ifdef MESI_RR_ARB_EN
  logic [1:0] ptr_q;
  assign pick = arb_pick(stalled, ptr_q);
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else if (state_q == FILL) ptr_q <= grant_q + 2'd1;
  end
`else
  assign pick = arb_pick(stalled, 2'd0);
`endif

  always_comb begin
    pick_op = BUS_RD;
    if (write[pick]) pick_op = hit_s[pick] ? BUS_UPGR : BUS_RDX;
  end

  // Shared copies all hold identical data, so OR-combining every holder
  // yields the block whether one owner (E/M) or several sharers respond.
  always_comb begin
    supplied    = 1'b0;
    supply_data = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (snoop_valid[i] && snoop_hit[i]) begin
        supplied    = 1'b1;
        supply_data = supply_data | snoop_data[i];
      end
    end
  end

  assign fill_data = (op_q == BUS_RD) ? bus_data_q
                                      : merge_word(bus_data_q, addr_q[3:2], wdata_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|stalled) state_d = SNOOP;
      SNOOP:   state_d = (op_q == BUS_UPGR || supplied) ? FILL : MEM;
      MEM:     if (mem_ready) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      op_q         <= BUS_RD;
      addr_q       <= '0;
      wdata_q      <= '0;
      bus_data_q   <= '0;
      fill_state_q <= I;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (|stalled) begin
          grant_q <= pick;
          op_q    <= pick_op;
          addr_q  <= pr_addr[pick];
          wdata_q <= pr_data[pick];
        end
        SNOOP: begin
          // An upgrade merges into the requester's own shared copy.
          if (op_q == BUS_UPGR) begin
            bus_data_q   <= snoop_data[grant_q];
            fill_state_q <= M;
          end else if (supplied) begin
            bus_data_q   <= supply_data;
            fill_state_q <= (op_q == BUS_RD) ? S : M;
          end else begin
            fill_state_q <= (op_q == BUS_RD) ? E : M;
          end
        end
        MEM: if (mem_ready) bus_data_q <= mem_read_data;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    mesi_l1_cache #(.NUM_LINES(NUM_LINES)) u_l1 (
      .clk         (clk),
      .rst         (rst),
      .req         (req[i]),
      .wr          (write[i]),
      .addr        (pr_addr[i]),
      .wdata       (pr_data[i]),
      .flush       (c_flush[i]),
      .local_hit   (local_hit[i]),
      .hit_s       (hit_s[i]),
      .rd_data     (data_out_pr[i]),
      .snoop_valid (snoop_valid[i]),
      .snoop_op    (op_q),
      .bus_addr    (addr_q),
      .snoop_hit   (snoop_hit[i]),
      .snoop_data  (snoop_data[i]),
      .fill_en     (fill_en[i]),
      .fill_state  (fill_state_q),
      .fill_data   (fill_data)
    );
  end

endmodule

// File: tb/tb_mesi_cache_top.sv
// Directed self-checking bench for mesi_cache_top (default fixed-priority build).
module tb_mesi_cache_top;
  import mesi_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        read, write, Core_send, c_flush;
  logic [3:0][31:0]  pr_addr, pr_data;
  logic [127:0]      mem_read_data;
  logic              mem_ready;
  logic [3:0][31:0]  data_out_pr;
  logic              stall, stall_1, stall_2, stall_3;
  wire  [3:0]        stall_vec = {stall_3, stall_2, stall_1, stall};

  int vectors = 0;
  int miscompares = 0;
  int done_edge [4];

  localparam logic [127:0] BLK_A = 128'h123456789ABCDEF0123456789ABCDEF0;
  localparam logic [127:0] BLK_B = 128'hAAAA0003BBBB0002CCCC0001DDDD0000;

  mesi_cache_top dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .pr_addr(pr_addr),
    .pr_data(pr_data), .Core_send(Core_send), .c_flush(c_flush),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .data_out_pr(data_out_pr), .stall(stall), .stall_1(stall_1),
    .stall_2(stall_2), .stall_3(stall_3)
  );

  always #5 clk = ~clk;

  function automatic line_state_t peek_state(input int core, input int idx);
    case (core)
      0: return dut.g_core[0].u_l1.state_q[idx];
      1: return dut.g_core[1].u_l1.state_q[idx];
      2: return dut.g_core[2].u_l1.state_q[idx];
      default: return dut.g_core[3].u_l1.state_q[idx];
    endcase
  endfunction

  function automatic logic [31:0] peek_word(input int core, input int idx, input int w);
    logic [127:0] blk;
    case (core)
      0: blk = dut.g_core[0].u_l1.data_q[idx];
      1: blk = dut.g_core[1].u_l1.data_q[idx];
      2: blk = dut.g_core[2].u_l1.data_q[idx];
      default: blk = dut.g_core[3].u_l1.data_q[idx];
    endcase
    return blk[w*32 +: 32];
  endfunction

  task automatic drive(input int core, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    read[core]      = ~wr;
    write[core]     = wr;
    pr_addr[core]   = a;
    pr_data[core]   = d;
    Core_send[core] = 1'b1;
  endtask

  // Holds each masked request until its stall is seen low, lets it complete
  // on the following edge, then drops it. done_edge = edges from request
  // to stall low. mem_ready is raised after edge raise_at (if positive).
  task automatic run_bus(input logic [3:0] mask, input int budget, input int raise_at);
    logic [3:0] active, fin;
    int n;
    active = mask;
    n = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) done_edge[i] = -1;
    while (active != 0 && n < budget) begin
      #1;
      fin = active & ~stall_vec;
      for (int i = 0; i < 4; i++) if (fin[i]) done_edge[i] = n;
      @(posedge clk); #1; n++;
      if (n == raise_at) mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) if (fin[i]) begin
        Core_send[i] = 1'b0; read[i] = 1'b0; write[i] = 1'b0;
      end
      active = active & ~fin;
      if (active != 0) @(negedge clk);
    end
    if (active != 0) begin
      vectors++; miscompares++;
      $display("FAIL bus_timeout: cores still stalled %b, required none", active);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; c_flush = '0; mem_ready = 1'b0; mem_read_data = '0;
    read = '0; write = '0; pr_data = '0; pr_addr = '0;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (stall_vec[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stall[%0d]: got %b required 0", i, stall_vec[i]);
      end
    end
    Core_send = '0; read = '0; rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (data_out_pr[i] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_data[%0d]: got %h required 0", i, data_out_pr[i]);
      end
    end
  endtask

  task automatic test_four_reads();
    int exp_edge [4];
    exp_edge = '{4, 7, 11, 14};
    @(negedge clk);
    mem_ready = 1'b1; mem_read_data = BLK_A;
    drive(0, 1'b0, 32'h11111000, 32'h0);
    drive(1, 1'b0, 32'h11111000, 32'h0);
    drive(2, 1'b0, 32'h10000000, 32'h0);
    drive(3, 1'b0, 32'h10000000, 32'h0);
    run_bus(4'b1111, 80, -1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (done_edge[i] !== exp_edge[i]) begin
        miscompares++;
        $display("FAIL four_reads_latency[%0d]: got %0d edges required %0d", i, done_edge[i], exp_edge[i]);
      end
      vectors++;
      if (data_out_pr[i] !== 32'h9ABCDEF0) begin
        miscompares++;
        $display("FAIL four_reads_data[%0d]: got %h required 9abcdef0", i, data_out_pr[i]);
      end
      vectors++;
      if (peek_state(i, 0) !== S) begin
        miscompares++;
        $display("FAIL four_reads_state[%0d]: got %0d required S", i, peek_state(i, 0));
      end
    end
  endtask

  task automatic test_read_hit();
    @(negedge clk);
    drive(0, 1'b0, 32'h11111004, 32'h0);
    run_bus(4'b0001, 10, -1);
    vectors++;
    if (done_edge[0] !== 0) begin
      miscompares++;
      $display("FAIL read_hit_stall: stalled %0d edges required 0", done_edge[0]);
    end
    vectors++;
    if (data_out_pr[0] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL read_hit_data: got %h required 12345678", data_out_pr[0]);
    end
  endtask

  task automatic test_upgrade();
    @(negedge clk);
    drive(1, 1'b1, 32'h11111000, 32'hDEADBEEF);
    run_bus(4'b0010, 20, -1);
    vectors++;
    if (done_edge[1] !== 3) begin
      miscompares++;
      $display("FAIL upgrade_latency: got %0d edges required 3", done_edge[1]);
    end
    vectors++;
    if (data_out_pr[1] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL upgrade_echo: got %h required deadbeef", data_out_pr[1]);
    end
    vectors++;
    if (peek_state(1, 0) !== M || peek_state(0, 0) !== I) begin
      miscompares++;
      $display("FAIL upgrade_states: got c1=%0d c0=%0d required M,I", peek_state(1, 0), peek_state(0, 0));
    end
    @(negedge clk);
    drive(0, 1'b0, 32'h11111000, 32'h0);
    run_bus(4'b0001, 20, -1);
    vectors++;
    if (done_edge[0] !== 3) begin
      miscompares++;
      $display("FAIL reread_latency: got %0d edges required 3", done_edge[0]);
    end
    vectors++;
    if (data_out_pr[0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL reread_data: got %h required deadbeef", data_out_pr[0]);
    end
    vectors++;
    if (peek_state(0, 0) !== S || peek_state(1, 0) !== S) begin
      miscompares++;
      $display("FAIL reread_states: got c0=%0d c1=%0d required S,S", peek_state(0, 0), peek_state(1, 0));
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    c_flush = 4'b0001;
    @(posedge clk); #1;
    c_flush = '0;
    vectors++;
    if (peek_state(0, 0) !== I) begin
      miscompares++;
      $display("FAIL flush_state: got %0d required I", peek_state(0, 0));
    end
    @(negedge clk);
    drive(0, 1'b0, 32'h11111000, 32'h0);
    run_bus(4'b0001, 20, -1);
    vectors++;
    if (done_edge[0] !== 3) begin
      miscompares++;
      $display("FAIL flush_miss_latency: got %0d edges required 3", done_edge[0]);
    end
    vectors++;
    if (data_out_pr[0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL flush_miss_data: got %h required deadbeef", data_out_pr[0]);
    end
  endtask

  task automatic test_mem_wait();
    @(negedge clk);
    mem_ready = 1'b0; mem_read_data = BLK_B;
    drive(2, 1'b1, 32'h20000028, 32'h0BADF00D);
    run_bus(4'b0100, 40, 7);
    vectors++;
    if (done_edge[2] !== 9) begin
      miscompares++;
      $display("FAIL mem_wait_latency: got %0d edges required 9", done_edge[2]);
    end
    vectors++;
    if (data_out_pr[2] !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL mem_wait_echo: got %h required 0badf00d", data_out_pr[2]);
    end
    vectors++;
    if (peek_state(2, 2) !== M) begin
      miscompares++;
      $display("FAIL mem_wait_state: got %0d required M", peek_state(2, 2));
    end
    vectors++;
    if (peek_word(2, 2, 2) !== 32'h0BADF00D || peek_word(2, 2, 1) !== 32'hCCCC0001) begin
      miscompares++;
      $display("FAIL mem_wait_merge: got w2=%h w1=%h required 0badf00d,cccc0001",
               peek_word(2, 2, 2), peek_word(2, 2, 1));
    end
  endtask

  initial begin
    test_reset();
    test_four_reads();
    test_read_hit();
    test_upgrade();
    test_flush();
    test_mem_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
